// File: rtl/obi_tb_pkg.sv
// Shared widths and the response record carried from the handshake to the rvalid cycle
// of the OBI memory responder.
package obi_tb_pkg;

  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = 4;

  typedef struct packed {
    logic                  valid;
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_resp_t;

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-latency response pipe: a DEPTH-stage shift register of obi_resp_t.
// The synchronous clear drops every in-flight response.
module obi_resp_delay_line
  import obi_tb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_resp_t i_resp,
  output obi_resp_t o_resp
);

  obi_resp_t r_stage [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_resp;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_resp = r_stage[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI req/gnt/rvalid responder over a single-port word memory with programmable grant stall
// and fixed response latency. Define OBI_RESP_ERR_EN to add err_o for out-of-range addresses.
module obi_mem_responder
  import obi_tb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RVALID_DELAY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o
`ifdef OBI_RESP_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int unsigned WORD_W  = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 2 ** WORD_W;
  localparam int unsigned STALL_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [OUT_W-1:0]      r_outstanding;
  logic [OBI_DATA_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0]     w_word;
  logic                  w_stall_ok;
  logic                  w_hs;
  logic                  w_addr_err;
  logic                  w_unused;
  obi_resp_t             w_push;
  obi_resp_t             w_head;

  assign w_word = addr_i[ADDR_WIDTH-1:2];

  if (GNT_DELAY == 0) begin : g_no_stall
    assign w_stall_ok = 1'b1;
  end else begin : g_stall
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(GNT_DELAY);
    logic [STALL_W-1:0] r_stall_cnt;

    // Saturates at GNT_DELAY: once reached, only the outstanding limit can hold off the grant.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_stall_cnt <= '0;
      end else if (!req_i || w_hs) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != STALL_MAX) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end

    assign w_stall_ok = (r_stall_cnt >= STALL_MAX);
  end

  // Registered count only: a response retiring this cycle does not free a slot until next cycle.
  assign gnt_o = req_i & ~rst_i & w_stall_ok & (r_outstanding < OUT_MAX);
  assign w_hs  = req_i & gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_hs && !w_head.valid) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_hs && w_head.valid) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && we_i && !w_addr_err) begin
      for (int i = 0; i < int'(OBI_BE_W); i++) begin
        if (be_i[i]) begin
          r_mem[w_word][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    w_push       = '0;
    w_push.valid = w_hs;
    w_push.err   = w_hs & w_addr_err;
    if (w_hs && !we_i && !w_addr_err) begin
      w_push.rdata = r_mem[w_word];
    end
  end

  obi_resp_delay_line #(
    .DEPTH (RVALID_DELAY)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_resp (w_push),
    .o_resp (w_head)
  );

  assign rvalid_o = w_head.valid & ~rst_i;
  assign rdata_o  = rvalid_o ? w_head.rdata : '0;

`ifdef OBI_RESP_ERR_EN
  assign w_addr_err = |(addr_i >> ADDR_WIDTH);
  assign err_o      = rvalid_o & w_head.err;
  assign w_unused   = ^addr_i[1:0];
`else
  // Upper address bits alias into the array.
  assign w_addr_err = 1'b0;
  assign w_unused   = ^{addr_i[1:0], addr_i[31:ADDR_WIDTH], w_head.err};
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three configurations driven side by side, checked against a
// transaction-level model (pending-response queues and an associative word memory).
module tb_obi_mem_responder;

  localparam int unsigned AW = 16;
  localparam int NW = 2 ** (AW - 2);
`ifdef OBI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] rdata;
    bit          known;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [3];
  logic        gnt   [3];
  logic [31:0] addr  [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
`ifdef OBI_RESP_ERR_EN
  logic        err   [3];
  logic        obs_err[3];
`endif

  logic        c_req  [3];
  logic [31:0] c_addr [3];
  logic        c_we   [3];
  logic [3:0]  c_be   [3];
  logic [31:0] c_wdata[3];

  logic        obs_g  [3];
  logic        obs_rv [3];
  logic [31:0] obs_rd [3];

  exp_t        pq [3][$];
  int          stall [3];
  logic [31:0] mem_m [int];
  int          hs_log [3][$];
  int          rv_log [3][$];
  logic [31:0] rv_dat [3][$];
  int          init_k [3];
  int          cyc, checks, errors;
  int          t0, k, cnt;
  int          exp_hs_a [4] = '{0, 1, 5, 6};
  int          exp_rv_a [4] = '{4, 5, 9, 10};

  always #5 clk = ~clk;

  obi_mem_responder #(.ADDR_WIDTH(AW), .GNT_DELAY(0), .RVALID_DELAY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
`ifdef OBI_RESP_ERR_EN
    , .err_o(err[0])
`endif
  );

  obi_mem_responder #(.ADDR_WIDTH(AW), .GNT_DELAY(3), .RVALID_DELAY(1), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
`ifdef OBI_RESP_ERR_EN
    , .err_o(err[1])
`endif
  );

  obi_mem_responder #(.ADDR_WIDTH(AW), .GNT_DELAY(0), .RVALID_DELAY(4), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2])
`ifdef OBI_RESP_ERR_EN
    , .err_o(err[2])
`endif
  );

  function automatic int gd(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int rd(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic int mo(input int d);
    return (d == 1) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d observed=%h expected=%h", tag, d, cyc, obs, expv);
    end
  endtask

  task automatic set_cmd(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd);
    c_req[d]   = 1'b1;
    c_we[d]    = w;
    c_addr[d]  = a;
    c_be[d]    = b;
    c_wdata[d] = wd;
  endtask

  // Model of one accepted request: memory effect now, response due RVALID_DELAY cycles later.
  task automatic access(input int d);
    exp_t        e;
    bit          er;
    int          key;
    logic [31:0] w;
    er      = ERR_EN && (c_addr[d][31:AW] != 16'h0);
    key     = d * NW + int'(c_addr[d][AW-1:2]);
    e.due   = cyc + rd(d);
    e.err   = er;
    e.known = 1'b1;
    e.rdata = 32'h0;
    if (c_we[d]) begin
      if (!er) begin
        if (mem_m.exists(key)) begin
          w = mem_m[key];
          for (int b = 0; b < 4; b++) if (c_be[d][b]) w[8*b +: 8] = c_wdata[d][8*b +: 8];
          mem_m[key] = w;
        end else if (c_be[d] == 4'hF) begin
          mem_m[key] = c_wdata[d];
        end
      end
    end else if (!er) begin
      if (mem_m.exists(key)) e.rdata = mem_m[key];
      else e.known = 1'b0;
    end
    pq[d].push_back(e);
  endtask

  task automatic cycle(input bit rst_v);
    @(posedge clk);
    #1;
    rst = rst_v;
    for (int d = 0; d < 3; d++) begin
      req[d] = c_req[d]; addr[d] = c_addr[d]; we[d] = c_we[d];
      be[d] = c_be[d]; wdata[d] = c_wdata[d];
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      bit   eg, erv;
      exp_t e;
      obs_g[d]  = gnt[d];
      obs_rv[d] = rvalid[d];
      obs_rd[d] = rdata[d];
`ifdef OBI_RESP_ERR_EN
      obs_err[d] = err[d];
`endif
      eg  = !rst_v && c_req[d] && (stall[d] >= gd(d)) && (pq[d].size() < mo(d));
      erv = !rst_v && (pq[d].size() > 0) && (pq[d][0].due == cyc);
      chk("gnt", d, 32'(gnt[d]), 32'(eg));
      chk("rvalid", d, 32'(rvalid[d]), 32'(erv));
      if (erv) begin
        e = pq[d].pop_front();
        if (e.known) chk("rdata", d, rdata[d], e.rdata);
`ifdef OBI_RESP_ERR_EN
        chk("err", d, 32'(err[d]), 32'(e.err));
`endif
      end else begin
        chk("rdata_idle", d, rdata[d], 32'h0);
`ifdef OBI_RESP_ERR_EN
        chk("err_idle", d, 32'(err[d]), 32'h0);
`endif
      end
      if (gnt[d] && c_req[d]) hs_log[d].push_back(cyc);
      if (rvalid[d]) begin
        rv_log[d].push_back(cyc);
        rv_dat[d].push_back(rdata[d]);
      end
      if (rst_v) begin
        pq[d].delete();
        stall[d] = 0;
      end else if (eg) begin
        access(d);
        stall[d] = 0;
      end else if (c_req[d]) begin
        stall[d]++;
      end else begin
        stall[d] = 0;
      end
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int d = 0; d < 3; d++) begin
      set_cmd(d, 1'b0, 32'h0, 4'hF, 32'h0);
      stall[d]  = 0;
      init_k[d] = 0;
    end

    // Reset held with req high.
    repeat (3) begin
      cycle(1'b1);
      for (int d = 0; d < 3; d++) begin
        chk("t1_gnt", d, 32'(obs_g[d]), 32'h0);
        chk("t1_rvalid", d, 32'(obs_rv[d]), 32'h0);
        chk("t1_rdata", d, obs_rd[d], 32'h0);
      end
    end
    for (int d = 0; d < 3; d++) c_req[d] = 1'b0;
    cycle(1'b0);

    // Write then read, zero stall, one-cycle latency.
    set_cmd(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    cycle(1'b0);
    chk("t2_wr_gnt", 0, 32'(obs_g[0]), 32'h1);
    set_cmd(0, 1'b0, 32'h10, 4'hF, 32'h0);
    cycle(1'b0);
    chk("t2_rd_gnt", 0, 32'(obs_g[0]), 32'h1);
    chk("t2_wr_rvalid", 0, 32'(obs_rv[0]), 32'h1);
    chk("t2_wr_rdata", 0, obs_rd[0], 32'h0);
    c_req[0] = 1'b0;
    cycle(1'b0);
    chk("t2_rd_rvalid", 0, 32'(obs_rv[0]), 32'h1);
    chk("t2_rd_rdata", 0, obs_rd[0], 32'hDEADBEEF);
    cycle(1'b0);

    // Byte lanes.
    set_cmd(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    cycle(1'b0);
    set_cmd(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    cycle(1'b0);
    set_cmd(0, 1'b0, 32'h20, 4'hF, 32'h0);
    cycle(1'b0);
    c_req[0] = 1'b0;
    cycle(1'b0);
    chk("t3_rvalid", 0, 32'(obs_rv[0]), 32'h1);
    chk("t3_rdata", 0, obs_rd[0], 32'h11BB33DD);
    cycle(1'b0);

    // Grant stall of three cycles, then a dropped and reasserted request.
    set_cmd(1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk("t4_gnt_held", 1, 32'(obs_g[1]), 32'(i == 3));
    end
    c_req[1] = 1'b0;
    cycle(1'b0);
    chk("t4_rvalid", 1, 32'(obs_rv[1]), 32'h1);
    c_req[1] = 1'b1;
    repeat (2) begin
      cycle(1'b0);
      chk("t4_gnt_short", 1, 32'(obs_g[1]), 32'h0);
    end
    c_req[1] = 1'b0;
    cycle(1'b0);
    c_req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk("t4_gnt_reassert", 1, 32'(obs_g[1]), 32'(i == 3));
    end
    c_req[1] = 1'b0;
    repeat (2) cycle(1'b0);

    // Preload four words into the long-latency instance.
    k = 0;
    for (int i = 0; i < 30 && k < 4; i++) begin
      set_cmd(2, 1'b1, 32'(32'h40 + 4 * k), 4'hF, 32'(32'hA5000000 + k));
      cycle(1'b0);
      if (obs_g[2]) k++;
    end
    c_req[2] = 1'b0;
    chk("t5_preload", 2, k, 4);
    repeat (6) cycle(1'b0);

    // Four back-to-back reads against a 4-cycle latency and two outstanding.
    hs_log[2].delete(); rv_log[2].delete(); rv_dat[2].delete();
    t0 = cyc; k = 0;
    for (int i = 0; i < 20; i++) begin
      if (k < 4) set_cmd(2, 1'b0, 32'(32'h40 + 4 * k), 4'hF, 32'h0);
      else c_req[2] = 1'b0;
      cycle(1'b0);
      if (obs_g[2] && c_req[2]) k++;
    end
    chk("t5_hs_count", 2, hs_log[2].size(), 4);
    chk("t5_rv_count", 2, rv_log[2].size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_log[2].size()) chk("t5_hs_cycle", 2, hs_log[2][i] - t0, exp_hs_a[i]);
      if (i < rv_log[2].size()) begin
        chk("t5_rv_cycle", 2, rv_log[2][i] - t0, exp_rv_a[i]);
        chk("t5_rv_order", 2, rv_dat[2][i], 32'(32'hA5000000 + i));
      end
    end

    // Same traffic with reset in cycle 6: in-flight responses vanish.
    hs_log[2].delete(); rv_log[2].delete(); rv_dat[2].delete();
    t0 = cyc; k = 0;
    for (int i = 0; i < 16; i++) begin
      if (k < 4 && i < 6) set_cmd(2, 1'b0, 32'(32'h40 + 4 * k), 4'hF, 32'h0);
      else c_req[2] = 1'b0;
      cycle(i == 6);
      if (obs_g[2] && c_req[2]) k++;
    end
    cnt = 0;
    foreach (rv_log[2][j]) if (rv_log[2][j] - t0 >= 6) cnt++;
    chk("t5_hs_before_rst", 2, k, 3);
    chk("t5_rv_after_rst", 2, cnt, 0);
    chk("t5_rv_before_rst", 2, rv_log[2].size() - cnt, 2);

    // Upper address bits: alias, or error response with the write dropped.
    set_cmd(0, 1'b1, 32'h0001_0010, 4'hF, 32'hCAFEF00D);
    cycle(1'b0);
    set_cmd(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    cycle(1'b0);
    chk("t6_wr_rvalid", 0, 32'(obs_rv[0]), 32'h1);
`ifdef OBI_RESP_ERR_EN
    chk("t6_wr_err", 0, 32'(obs_err[0]), 32'h1);
`endif
    c_req[0] = 1'b0;
    cycle(1'b0);
    chk("t6_rd_rvalid", 0, 32'(obs_rv[0]), 32'h1);
`ifdef OBI_RESP_ERR_EN
    chk("t6_rd_rdata", 0, obs_rd[0], 32'hDEADBEEF);
`else
    chk("t6_rd_rdata", 0, obs_rd[0], 32'hCAFEF00D);
`endif
    repeat (2) cycle(1'b0);

    // Random traffic on all three instances with a mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (!c_req[d] || obs_g[d]) begin
          if (init_k[d] < 16) begin
            set_cmd(d, 1'b1, 32'(init_k[d] * 4), 4'hF, $urandom);
            init_k[d]++;
          end else begin
            c_req[d]   = ($urandom_range(0, 3) != 0);
            c_we[d]    = 1'($urandom_range(0, 1));
            c_addr[d]  = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0), 10'h0,
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            c_be[d]    = 4'($urandom);
            c_wdata[d] = $urandom;
          end
        end
      end
      cycle(i == 700 || i == 701);
    end
    for (int d = 0; d < 3; d++) c_req[d] = 1'b0;
    repeat (8) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
